branch_resolve_predict: RTL and testbench

//  Parametrised branch unit for the RV32 datapath. Holds a 2-bit saturating bimodal

---
 rtl/branch_resolve_predict_if.sv | 38 +++
 rtl/branch_resolve_predict.sv | 101 ++++++++++
 tb/tb_branch_resolve_predict.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/branch_resolve_predict_if.sv
// Branch unit bundle: IF-side prediction lookup, EX-side resolve request,
// registered resolve result and performance counters.
interface branch_resolve_predict_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic             res_valid;
    logic             res_flush;
    logic [XLEN-1:0]  res_pc;
    logic [2:0]       res_funct3;
    logic [XLEN-1:0]  res_rs1;
    logic [XLEN-1:0]  res_rs2;
    logic [XLEN-1:0]  res_target;
    logic             res_pred_taken;
    logic             out_valid;
    logic             out_taken;
    logic             out_mispredict;
    logic [XLEN-1:0]  out_redirect_pc;
    logic             out_illegal;
    logic [CNT_W-1:0] cnt_branches;
    logic [CNT_W-1:0] cnt_mispredicts;

    modport master (
        output pred_pc, res_valid, res_flush, res_pc, res_funct3, res_rs1, res_rs2,
               res_target, res_pred_taken,
        input  pred_taken, out_valid, out_taken, out_mispredict, out_redirect_pc,
               out_illegal, cnt_branches, cnt_mispredicts
    );

    modport slave (
        input  pred_pc, res_valid, res_flush, res_pc, res_funct3, res_rs1, res_rs2,
               res_target, res_pred_taken,
        output pred_taken, out_valid, out_taken, out_mispredict, out_redirect_pc,
               out_illegal, cnt_branches, cnt_mispredicts
    );
endinterface

// File: rtl/branch_resolve_predict.sv
// Bimodal 2-bit BHT predictor plus EX-stage branch resolver with registered
// redirect and saturating branch / mispredict counters.
module branch_resolve_predict #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned IDX_LSB     = 2,
    parameter int unsigned CNT_W       = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    branch_resolve_predict_if.slave bus
);
    localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic             out_valid_q, out_taken_q, out_mispredict_q, out_illegal_q;
    logic [XLEN-1:0]  out_redirect_pc_q;
    logic [CNT_W-1:0] cnt_branches_q, cnt_mispredicts_q;

    logic [IdxW-1:0]  pred_idx, res_idx;
    logic             acc, illegal, legal_acc, cond, taken, mispredict;
    logic [1:0]       ctr, ctr_next;
    logic [XLEN-1:0]  redirect_pc;

    assign pred_idx = bus.pred_pc[IDX_LSB +: IdxW];
    assign res_idx  = bus.res_pc[IDX_LSB +: IdxW];

    // No bypass: a same-cycle training write is not visible to the lookup.
    assign bus.pred_taken = bht_q[pred_idx][1];

    always_comb begin
        cond = 1'b0;
        case (bus.res_funct3)
            3'b000:  cond = (bus.res_rs1 == bus.res_rs2);
            3'b001:  cond = (bus.res_rs1 != bus.res_rs2);
            3'b100:  cond = ($signed(bus.res_rs1) < $signed(bus.res_rs2));
            3'b101:  cond = ($signed(bus.res_rs1) >= $signed(bus.res_rs2));
            3'b110:  cond = (bus.res_rs1 < bus.res_rs2);
            3'b111:  cond = (bus.res_rs1 >= bus.res_rs2);
            default: cond = 1'b0;
        endcase
    end

    assign acc         = bus.res_valid & ~bus.res_flush;
    assign illegal     = (bus.res_funct3[2:1] == 2'b01);
    assign legal_acc   = acc & ~illegal;
    assign taken       = legal_acc & cond;
    assign mispredict  = legal_acc & (taken != bus.res_pred_taken);
    assign redirect_pc = taken ? bus.res_target : bus.res_pc + XLEN'(4);

    assign ctr = bht_q[res_idx];

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != 2'b11) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) ctr_next = ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (legal_acc) begin
            bht_q[res_idx] <= ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q       <= 1'b0;
            out_taken_q       <= 1'b0;
            out_mispredict_q  <= 1'b0;
            out_illegal_q     <= 1'b0;
            out_redirect_pc_q <= '0;
            cnt_branches_q    <= '0;
            cnt_mispredicts_q <= '0;
        end else begin
            out_valid_q      <= acc;
            out_taken_q      <= taken;
            out_mispredict_q <= mispredict;
            out_illegal_q    <= acc & illegal;
            if (acc) out_redirect_pc_q <= redirect_pc;
            if (legal_acc && cnt_branches_q != '1) cnt_branches_q <= cnt_branches_q + 1'b1;
            if (mispredict && cnt_mispredicts_q != '1) begin
                cnt_mispredicts_q <= cnt_mispredicts_q + 1'b1;
            end
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_taken       = out_taken_q;
    assign bus.out_mispredict  = out_mispredict_q;
    assign bus.out_illegal     = out_illegal_q;
    assign bus.out_redirect_pc = out_redirect_pc_q;
    assign bus.cnt_branches    = cnt_branches_q;
    assign bus.cnt_mispredicts = cnt_mispredicts_q;
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench: driver pushes per-cycle expected results into a queue, a
// negedge monitor pops and compares them against the registered outputs.
module tb_branch_resolve_predict;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_resolve_predict_if #(.XLEN(32), .CNT_W(CW)) bus ();

    branch_resolve_predict #(
        .XLEN(32), .BHT_ENTRIES(64), .IDX_LSB(2), .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic          v, t, m, il;
        logic [31:0]   rd;
        logic [CW-1:0] cb, cm;
    } exp_t;

    exp_t          q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [1:0]    bht_m [64];
    logic [31:0]   red_m = '0;
    logic [CW-1:0] cb_m = '0, cm_m = '0;
    bit            model_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out_valid",       32'(bus.out_valid),       32'(e.v));
            chk("out_taken",       32'(bus.out_taken),       32'(e.t));
            chk("out_mispredict",  32'(bus.out_mispredict),  32'(e.m));
            chk("out_illegal",     32'(bus.out_illegal),     32'(e.il));
            chk("out_redirect_pc", bus.out_redirect_pc,      e.rd);
            chk("cnt_branches",    32'(bus.cnt_branches),    32'(e.cb));
            chk("cnt_mispredicts", 32'(bus.cnt_mispredicts), 32'(e.cm));
        end
    end

    // exp_tk is the hand-derived branch direction for the given operands.
    task automatic step(input logic rst, input logic v, input logic fl, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pr, input logic [31:0] ppc,
                        input logic exp_tk);
        exp_t e;
        logic acc, il, tk, ms;
        rst_n              = rst;
        bus.res_valid      = v;
        bus.res_flush      = fl;
        bus.res_funct3     = f3;
        bus.res_rs1        = rs1;
        bus.res_rs2        = rs2;
        bus.res_pc         = pc;
        bus.res_target     = tgt;
        bus.res_pred_taken = pr;
        bus.pred_pc        = ppc;
        #1;
        if (model_ok) chk("pred_taken", 32'(bus.pred_taken), 32'(bht_m[ppc[7:2]][1]));
        if (!rst) begin
            for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
            red_m = '0; cb_m = '0; cm_m = '0; model_ok = 1'b1;
            e.v = 0; e.t = 0; e.m = 0; e.il = 0;
        end else begin
            acc = v & ~fl;
            il  = acc & (f3 == 3'b010 || f3 == 3'b011);
            tk  = acc & ~il & exp_tk;
            ms  = acc & ~il & (tk != pr);
            e.v = acc; e.t = tk; e.m = ms; e.il = il;
            if (acc) red_m = tk ? tgt : pc + 32'd4;
            if (acc && !il) begin
                if (cb_m != {CW{1'b1}}) cb_m = cb_m + 1'b1;
                if (ms && cm_m != {CW{1'b1}}) cm_m = cm_m + 1'b1;
                if (tk && bht_m[pc[7:2]] != 2'b11) bht_m[pc[7:2]] = bht_m[pc[7:2]] + 2'd1;
                if (!tk && bht_m[pc[7:2]] != 2'b00) bht_m[pc[7:2]] = bht_m[pc[7:2]] - 2'd1;
            end
        end
        e.rd = red_m; e.cb = cb_m; e.cm = cm_m;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input logic [31:0] ppc);
        step(1'b1, 1'b0, 1'b0, 3'b000, '0, '0, '0, '0, 1'b0, ppc, 1'b0);
    endtask

    task automatic res(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pr,
                       input logic [31:0] ppc, input logic exp_tk);
        step(1'b1, 1'b1, 1'b0, f3, rs1, rs2, pc, tgt, pr, ppc, exp_tk);
    endtask

    initial begin
        // Reset
        step(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 32'h100, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 32'h100, 1'b0);
        for (int i = 0; i < 64; i++) idle(32'(i * 4));

        // BEQ taken, predicted not-taken
        res(3'b000, 32'd5, 32'd5, 32'h100, 32'h80, 1'b0, 32'h100, 1'b1);
        idle(32'h100);

        // Signed vs unsigned, other funct3, pc+4 wrap
        res(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b0, 32'h0, 1'b1);
        res(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b0, 32'h0, 1'b0);
        res(3'b001, 32'd3, 32'd4, 32'h204, 32'h400, 1'b1, 32'h0, 1'b1);
        res(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 32'h208, 32'h500, 1'b0, 32'h0, 1'b1);
        res(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h20C, 32'h600, 1'b1, 32'h0, 1'b0);
        res(3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h700, 1'b0, 32'h0, 1'b0);
        idle(32'h0);

        // Illegal funct3 and flushed branch
        res(3'b010, 32'd5, 32'd5, 32'h100, 32'h900, 1'b1, 32'h100, 1'b0);
        res(3'b011, 32'd5, 32'd5, 32'h100, 32'h900, 1'b0, 32'h100, 1'b0);
        step(1'b1, 1'b1, 1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 32'hA00, 1'b0, 32'h100, 1'b1);
        idle(32'h100);

        // Saturation on one index with collision on the lookup
        for (int i = 0; i < 5; i++) res(3'b000, 32'd7, 32'd7, 32'h400, 32'h40, 1'b1, 32'h400, 1'b1);
        res(3'b000, 32'd1, 32'd2, 32'h400, 32'h40, 1'b1, 32'h400, 1'b0);
        idle(32'h400);
        res(3'b000, 32'd0, 32'd0, 32'h500, 32'h50, 1'b0, 32'h500, 1'b1);
        idle(32'h500);

        // Counter saturation: drive mispredicts past all-ones
        for (int i = 0; i < 18; i++) begin
            res(3'b000, 32'd9, 32'd9, 32'(32'h600 + i * 4), 32'h60, 1'b0, 32'h0, 1'b1);
        end
        idle(32'h600);

        // Reset during a resolve
        step(1'b0, 1'b1, 1'b0, 3'b000, 32'd1, 32'd1, 32'h100, 32'h10, 1'b0, 32'h100, 1'b1);
        idle(32'h100);
        idle(32'h400);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
